mux_arbiter: RTL and testbench

Round-robin arbiter that shares the existing 4:1 single-bit mux (`mux`: inputs a/b/c/d, select `sig[1:0]`, output `result`) among four requesters. The arbiter grants one requester at a time and drives the mux select. It bounds each grant to `HOLD_MAX` cycles and registers the selected bit with a valid flag. It sits between the four source channels and the single downstream consumer of the muxed bit.

---
 rtl/mux_arb_pkg.sv | 35 +++
 rtl/mux_arbiter_if.sv | 26 ++
 rtl/mux.sv | 13 +
 rtl/mux_arbiter.sv | 97 +++++++++
 tb/tb_mux_arbiter.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types, sizes and round-robin search for mux_arbiter
package mux_arb_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First requesting channel at or after ptr (mod NUM_CH), optionally skipping one index.
  function automatic pick_t rr_pick(input logic [NUM_CH-1:0] req,
                                    input logic [SEL_W-1:0]  ptr,
                                    input logic              excl_en,
                                    input logic [SEL_W-1:0]  excl_idx);
    pick_t            p;
    logic [SEL_W-1:0] idx;
    p = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ptr + SEL_W'(i);
      if (!p.found && req[idx] && !(excl_en && (idx == excl_idx))) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// rtl/mux_arbiter_if.sv - requester/data bundle between source channels and mux_arbiter
interface mux_arbiter_if;
  import mux_arb_pkg::*;

  logic [NUM_CH-1:0] req;
  logic              a;
  logic              b;
  logic              c;
  logic              d;
  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic              result;
  logic              valid;

  modport master (
    output req, a, b, c, d,
    input  gnt, sel, busy, result, valid
  );

  modport slave (
    input  req, a, b, c, d,
    output gnt, sel, busy, result, valid
  );

endinterface

// File: rtl/mux.sv
// rtl/mux.sv - existing 4:1 single-bit mux
module mux (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic [1:0] sig,
  output logic       result
);

  assign result = sig[1] ? (sig[0] ? d : c) : (sig[0] ? b : a);

endmodule

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin arbiter sharing the 4:1 mux, bounded hold, registered data
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_arbiter_if.slave   bus
);

  state_t            state, state_d;
  logic [NUM_CH-1:0] gnt_r, gnt_d;
  logic [SEL_W-1:0]  sel_r, sel_d;
  logic [SEL_W-1:0]  ptr, ptr_d;
  logic [3:0]        hold_cnt, hold_d;
  logic              result_r;
  logic              valid_r;
  logic              mux_out;
  logic              rel;
  pick_t             pick;

  mux u_mux (
    .a      (bus.a),
    .b      (bus.b),
    .c      (bus.c),
    .d      (bus.d),
    .sig    (sel_r),
    .result (mux_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_r    <= '0;
      sel_r    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      gnt_r    <= gnt_d;
      sel_r    <= sel_d;
      ptr      <= ptr_d;
      hold_cnt <= hold_d;
    end
  end

  always_comb begin
    state_d = state;
    gnt_d   = gnt_r;
    sel_d   = sel_r;
    ptr_d   = ptr;
    hold_d  = hold_cnt;
    rel     = 1'b0;
    // While granted, the current owner is excluded so a release hands off to someone else.
    pick    = rr_pick(bus.req, ptr, state == GRANT, sel_r);

    if (state == GRANT) begin
      rel = !bus.req[sel_r] || (hold_cnt == 4'(HOLD_MAX));
    end

    if ((state == IDLE || rel) && pick.found) begin
      state_d = GRANT;
      gnt_d   = NUM_CH'(1) << pick.idx;
      sel_d   = pick.idx;
      hold_d  = 4'd1;
      ptr_d   = pick.idx + SEL_W'(1);
    end else if (state == GRANT && !rel) begin
      hold_d = hold_cnt + 4'd1;
    end else if (state == GRANT && bus.req[sel_r]) begin
      hold_d = 4'd1;
    end else if (state == GRANT) begin
      state_d = IDLE;
      gnt_d   = '0;
      hold_d  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_r <= 1'b0;
      valid_r  <= 1'b0;
    end else if (state == GRANT) begin
      result_r <= mux_out;
      valid_r  <= 1'b1;
    end else begin
      valid_r  <= 1'b0;
    end
  end

  assign bus.gnt    = gnt_r;
  assign bus.sel    = sel_r;
  assign bus.busy   = (state == GRANT);
  assign bus.result = result_r;
  assign bus.valid  = valid_r;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - directed self-checking bench for mux_arbiter with HOLD_MAX=4
module tb_mux_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux_arbiter_if bus ();

  mux_arbiter #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic bz, input logic v);
    chk({tag, ".gnt"},   8'(bus.gnt),   8'(g));
    chk({tag, ".sel"},   8'(bus.sel),   8'(s));
    chk({tag, ".busy"},  8'(bus.busy),  8'(bz));
    chk({tag, ".valid"}, 8'(bus.valid), 8'(v));
  endtask

  task automatic set_data(input logic [3:0] dv);
    bus.a = dv[0];
    bus.b = dv[1];
    bus.c = dv[2];
    bus.d = dv[3];
  endtask

  initial begin
    logic [3:0] dat;
    int         ch;
    int         prev_ch;

    rst_n   = 1'b0;
    bus.req = 4'b0000;
    set_data(4'b0000);
    tick();
    tick();
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("reset.result", 8'(bus.result), 8'd0);

    // single request on a
    rst_n   = 1'b1;
    bus.req = 4'b0001;
    set_data(4'b0001);
    tick();
    chk_all("single.e1", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    chk_all("single.e2", 4'b0001, 2'd0, 1'b1, 1'b1);
    chk("single.e2.result", 8'(bus.result), 8'd1);
    bus.req = 4'b0000;
    tick();
    chk_all("single.drop", 4'b0000, 2'd0, 1'b0, 1'b1);
    chk("single.drop.result", 8'(bus.result), 8'd1);
    tick();
    chk_all("single.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("single.idle.result", 8'(bus.result), 8'd1);

    // reset to bring ptr back to 0, then all four request continuously
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    tick();
    chk_all("rst2", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    dat   = 4'b0101;
    set_data(dat);
    prev_ch = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      ch = (j / 4) % 4;
      chk_all($sformatf("rot.c%0d", j), 4'(1 << ch), 2'(ch), 1'b1, (j > 0));
      if (j > 0) chk($sformatf("rot.c%0d.result", j), 8'(bus.result), 8'(dat[prev_ch]));
      prev_ch = ch;
    end

    // wrap-around: c granted, then req=1001 gives d then a
    bus.req = 4'b0100;
    tick();
    chk_all("wrap.c", 4'b0100, 2'd2, 1'b1, 1'b1);
    bus.req = 4'b1001;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_all($sformatf("wrap.d%0d", j), 4'b1000, 2'd3, 1'b1, 1'b1);
    end
    tick();
    chk_all("wrap.a", 4'b0001, 2'd0, 1'b1, 1'b1);

    // sole requester c across hold expiries
    bus.req = 4'b0100;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk_all($sformatf("sole.c%0d", j), 4'b0100, 2'd2, 1'b1, 1'b1);
    end
    // competitor b arrives at hold_cnt=2; c keeps two more cycles
    bus.req = 4'b0110;
    tick();
    chk_all("sole.h3", 4'b0100, 2'd2, 1'b1, 1'b1);
    tick();
    chk_all("sole.h4", 4'b0100, 2'd2, 1'b1, 1'b1);
    tick();
    chk_all("sole.tob", 4'b0010, 2'd1, 1'b1, 1'b1);

    // b drops while d arrives in the same cycle
    bus.req = 4'b1000;
    tick();
    chk_all("simul.d", 4'b1000, 2'd3, 1'b1, 1'b1);

    // reset mid-grant of b
    bus.req = 4'b0010;
    set_data(4'b0110);
    tick();
    chk_all("midrst.b", 4'b0010, 2'd1, 1'b1, 1'b1);
    chk("midrst.b.result", 8'(bus.result), 8'd0);
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    tick();
    chk_all("midrst.rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("midrst.rst.result", 8'(bus.result), 8'd0);
    rst_n = 1'b1;
    tick();
    chk_all("midrst.a", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
